// File: rtl/audio_cfg_arbiter_if.sv
// Bundle of requester command/response signals and the AXI4-Lite
// configuration master port of audio_cfg_arbiter.
// master = arbiter view, slave = environment (requesters + cfg slave) view.
interface audio_cfg_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // requester 0
  logic              req0_valid_i;
  logic              req0_we_i;
  logic [ADDR_W-1:0] req0_addr_i;
  logic [DATA_W-1:0] req0_wdata_i;
  logic              req0_ready_o;
  logic              req0_done_o;
  logic [DATA_W-1:0] req0_rdata_o;
  logic [1:0]        req0_resp_o;
  // requester 1
  logic              req1_valid_i;
  logic              req1_we_i;
  logic [ADDR_W-1:0] req1_addr_i;
  logic [DATA_W-1:0] req1_wdata_i;
  logic              req1_ready_o;
  logic              req1_done_o;
  logic [DATA_W-1:0] req1_rdata_o;
  logic [1:0]        req1_resp_o;
  // AXI4-Lite configuration port
  logic                cfg_awvalid_o;
  logic [ADDR_W-1:0]   cfg_awaddr_o;
  logic                cfg_wvalid_o;
  logic [DATA_W-1:0]   cfg_wdata_o;
  logic [DATA_W/8-1:0] cfg_wstrb_o;
  logic                cfg_bready_o;
  logic                cfg_arvalid_o;
  logic [ADDR_W-1:0]   cfg_araddr_o;
  logic                cfg_rready_o;
  logic                cfg_awready_i;
  logic                cfg_wready_i;
  logic                cfg_bvalid_i;
  logic [1:0]          cfg_bresp_i;
  logic                cfg_arready_i;
  logic                cfg_rvalid_i;
  logic [DATA_W-1:0]   cfg_rdata_i;
  logic [1:0]          cfg_rresp_i;
  // status
  logic                busy_o;

  modport master (
    input  req0_valid_i, req0_we_i, req0_addr_i, req0_wdata_i,
    output req0_ready_o, req0_done_o, req0_rdata_o, req0_resp_o,
    input  req1_valid_i, req1_we_i, req1_addr_i, req1_wdata_i,
    output req1_ready_o, req1_done_o, req1_rdata_o, req1_resp_o,
    output cfg_awvalid_o, cfg_awaddr_o, cfg_wvalid_o, cfg_wdata_o, cfg_wstrb_o,
    output cfg_bready_o, cfg_arvalid_o, cfg_araddr_o, cfg_rready_o,
    input  cfg_awready_i, cfg_wready_i, cfg_bvalid_i, cfg_bresp_i,
    input  cfg_arready_i, cfg_rvalid_i, cfg_rdata_i, cfg_rresp_i,
    output busy_o
  );

  modport slave (
    output req0_valid_i, req0_we_i, req0_addr_i, req0_wdata_i,
    input  req0_ready_o, req0_done_o, req0_rdata_o, req0_resp_o,
    output req1_valid_i, req1_we_i, req1_addr_i, req1_wdata_i,
    input  req1_ready_o, req1_done_o, req1_rdata_o, req1_resp_o,
    input  cfg_awvalid_o, cfg_awaddr_o, cfg_wvalid_o, cfg_wdata_o, cfg_wstrb_o,
    input  cfg_bready_o, cfg_arvalid_o, cfg_araddr_o, cfg_rready_o,
    output cfg_awready_i, cfg_wready_i, cfg_bvalid_i, cfg_bresp_i,
    output cfg_arready_i, cfg_rvalid_i, cfg_rdata_i, cfg_rresp_i,
    input  busy_o
  );
endinterface

// File: rtl/audio_cfg_arbiter.sv
// Two-requester round-robin arbiter that turns single-word register
// commands into one complete AXI4-Lite transaction at a time and routes
// the response back to the requester that issued the command.
module audio_cfg_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  audio_cfg_arbiter_if.master bus
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;     // 1 = requester 1 served last
  logic                owner_q, owner_d;   // requester of the command in flight
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                done0_q, done0_d;
  logic                done1_q, done1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic [1:0]          resp0_q, resp0_d;
  logic [1:0]          resp1_q, resp1_d;
  logic                busy_q, busy_d;

  logic                grant_s;
  logic                idle_s;
  logic                ready0_s, ready1_s, accept_s;
  logic                acc_we_s;
  logic [ADDR_W-1:0]   acc_addr_s;
  logic [DATA_W-1:0]   acc_wdata_s;
  logic                aw_left_s, w_left_s;

  // Round-robin grant: a lone valid wins, contention goes to the one not served last
  always_comb begin
    grant_s = 1'b0;
    if (bus.req0_valid_i && !bus.req1_valid_i) begin
      grant_s = 1'b0;
    end else if (!bus.req0_valid_i && bus.req1_valid_i) begin
      grant_s = 1'b1;
    end else if (bus.req0_valid_i && bus.req1_valid_i) begin
      grant_s = ~last_q;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Ready is gated by rst_i so nothing is offered while reset is held
  assign idle_s   = rst_i && (state_q == IDLE);
  assign ready0_s = idle_s && bus.req0_valid_i && !grant_s;
  assign ready1_s = idle_s && bus.req1_valid_i && grant_s;
  assign accept_s = ready0_s || ready1_s;

  assign acc_we_s    = grant_s ? bus.req1_we_i    : bus.req0_we_i;
  assign acc_addr_s  = grant_s ? bus.req1_addr_i  : bus.req0_addr_i;
  assign acc_wdata_s = grant_s ? bus.req1_wdata_i : bus.req0_wdata_i;

  // AW and W each stay pending until their own handshake
  assign aw_left_s = awvalid_q && !bus.cfg_awready_i;
  assign w_left_s  = wvalid_q && !bus.cfg_wready_i;

  // Transaction sequencer: next state and next value of every registered output
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    resp0_d   = resp0_q;
    resp1_d   = resp1_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          owner_d = grant_s;
          last_d  = grant_s;
          if (acc_we_s) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = acc_addr_s;
            wdata_d   = acc_wdata_s;
            wstrb_d   = {STRB_W{1'b1}};
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
            araddr_d  = acc_addr_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR_REQ: begin
        awvalid_d = aw_left_s;
        wvalid_d  = w_left_s;
        if (!aw_left_s && !w_left_s) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end else begin
          state_d = WR_REQ;
        end
      end
      WR_RESP: begin
        if (bus.cfg_bvalid_i) begin
          state_d  = DONE;
          bready_d = 1'b0;
          if (owner_q) begin
            done1_d  = 1'b1;
            rdata1_d = {DATA_W{1'b0}};
            resp1_d  = bus.cfg_bresp_i;
          end else begin
            done0_d  = 1'b1;
            rdata0_d = {DATA_W{1'b0}};
            resp0_d  = bus.cfg_bresp_i;
          end
        end else begin
          state_d = WR_RESP;
        end
      end
      RD_REQ: begin
        if (bus.cfg_arready_i) begin
          state_d   = RD_RESP;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_RESP: begin
        if (bus.cfg_rvalid_i) begin
          state_d  = DONE;
          rready_d = 1'b0;
          if (owner_q) begin
            done1_d  = 1'b1;
            rdata1_d = bus.cfg_rdata_i;
            resp1_d  = bus.cfg_rresp_i;
          end else begin
            done0_d  = 1'b1;
            rdata0_d = bus.cfg_rdata_i;
            resp0_d  = bus.cfg_rresp_i;
          end
        end else begin
          state_d = RD_RESP;
        end
      end
      DONE: begin
        state_d = IDLE;
        wstrb_d = {STRB_W{1'b0}};
      end
      default: begin
        state_d   = IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        wstrb_d   = {STRB_W{1'b0}};
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset discards any command in flight
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= {ADDR_W{1'b0}};
      araddr_q  <= {ADDR_W{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
      wstrb_q   <= {STRB_W{1'b0}};
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      rdata0_q  <= {DATA_W{1'b0}};
      rdata1_q  <= {DATA_W{1'b0}};
      resp0_q   <= 2'b00;
      resp1_q   <= 2'b00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      resp0_q   <= resp0_d;
      resp1_q   <= resp1_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.req0_ready_o  = ready0_s;
  assign bus.req1_ready_o  = ready1_s;
  assign bus.req0_done_o   = done0_q;
  assign bus.req1_done_o   = done1_q;
  assign bus.req0_rdata_o  = rdata0_q;
  assign bus.req1_rdata_o  = rdata1_q;
  assign bus.req0_resp_o   = resp0_q;
  assign bus.req1_resp_o   = resp1_q;
  assign bus.cfg_awvalid_o = awvalid_q;
  assign bus.cfg_awaddr_o  = awaddr_q;
  assign bus.cfg_wvalid_o  = wvalid_q;
  assign bus.cfg_wdata_o   = wdata_q;
  assign bus.cfg_wstrb_o   = wstrb_q;
  assign bus.cfg_bready_o  = bready_q;
  assign bus.cfg_arvalid_o = arvalid_q;
  assign bus.cfg_araddr_o  = araddr_q;
  assign bus.cfg_rready_o  = rready_q;
  assign bus.busy_o        = busy_q;

endmodule

// File: tb/tb_audio_cfg_arbiter.sv
// Directed self-checking bench for audio_cfg_arbiter: the bench plays both
// requesters and the AXI4-Lite slave step by step.
module tb_audio_cfg_arbiter;

  logic clk_i = 1'b0;
  logic rst_i;
  int   total = 0;
  int   bad   = 0;
  int   n;

  audio_cfg_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  audio_cfg_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // advance past the next active edge and settle
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    bus.cfg_awready_i = 1'b0;
    bus.cfg_wready_i  = 1'b0;
    bus.cfg_bvalid_i  = 1'b0;
    bus.cfg_bresp_i   = 2'b00;
    bus.cfg_arready_i = 1'b0;
    bus.cfg_rvalid_i  = 1'b0;
    bus.cfg_rdata_i   = 32'h0;
    bus.cfg_rresp_i   = 2'b00;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1;
    bus.req0_valid_i = 1'b1; bus.req0_we_i = 1'b1;
    bus.req0_addr_i  = 32'h0000_0010; bus.req0_wdata_i = 32'hA5A5_0001;
    bus.req1_valid_i = 1'b1; bus.req1_we_i = 1'b0;
    bus.req1_addr_i  = 32'h0000_0014; bus.req1_wdata_i = 32'h0;
    slave_idle();
    #2 rst_i = 1'b0;

    // ---------------- reset with both valids high
    tick(); tick();
    chk("rst_ready0",  32'(bus.req0_ready_o),  32'd0);
    chk("rst_ready1",  32'(bus.req1_ready_o),  32'd0);
    chk("rst_busy",    32'(bus.busy_o),        32'd0);
    chk("rst_valids",  {bus.cfg_awvalid_o, bus.cfg_wvalid_o, bus.cfg_arvalid_o,
                        bus.cfg_bready_o, bus.cfg_rready_o}, 64'd0);
    chk("rst_done",    {bus.req0_done_o, bus.req1_done_o}, 64'd0);
    chk("rst_addr",    {bus.cfg_awaddr_o, bus.cfg_araddr_o}, 64'd0);
    chk("rst_wdata",   {bus.cfg_wdata_o, 28'd0, bus.cfg_wstrb_o}, 64'd0);
    chk("rst_rdata",   {bus.req0_rdata_o, bus.req1_rdata_o}, 64'd0);
    chk("rst_resp",    {bus.req0_resp_o, bus.req1_resp_o}, 64'd0);

    // ---------------- release: requester 0 wins first contention
    rst_i = 1'b1;
    #1;
    chk("rel_ready0", 32'(bus.req0_ready_o), 32'd1);
    chk("rel_ready1", 32'(bus.req1_ready_o), 32'd0);

    // ---------------- single write, zero-wait slave
    bus.req1_valid_i  = 1'b0;
    bus.cfg_awready_i = 1'b1; bus.cfg_wready_i = 1'b1;
    bus.cfg_bvalid_i  = 1'b1; bus.cfg_bresp_i  = 2'b00;
    tick(); // acceptance edge T
    bus.req0_valid_i = 1'b0;
    chk("wr_awvalid", {bus.cfg_awvalid_o, bus.cfg_wvalid_o}, 64'h3);
    chk("wr_awaddr",  bus.cfg_awaddr_o, 64'h10);
    chk("wr_wdata",   bus.cfg_wdata_o,  64'hA5A5_0001);
    chk("wr_wstrb",   bus.cfg_wstrb_o,  64'hF);
    chk("wr_busy",    {bus.busy_o, bus.req0_ready_o}, 64'h2);
    tick(); // AW/W handshake T+1
    chk("wr_valids_drop", {bus.cfg_awvalid_o, bus.cfg_wvalid_o}, 64'h0);
    chk("wr_bready",  32'(bus.cfg_bready_o), 32'd1);
    chk("wr_no_done_yet", 32'(bus.req0_done_o), 32'd0);
    tick(); // B captured T+2
    chk("wr_done0",   {bus.req0_done_o, bus.req1_done_o}, 64'h2);
    chk("wr_resp0",   bus.req0_resp_o,  64'h0);
    chk("wr_rdata0",  bus.req0_rdata_o, 64'h0);
    chk("wr_bready_drop", 32'(bus.cfg_bready_o), 32'd0);
    tick();
    chk("wr_done_pulse", 32'(bus.req0_done_o), 32'd0);
    chk("wr_idle",    32'(bus.busy_o), 32'd0);
    slave_idle();

    // ---------------- read with stalls from requester 1
    bus.req1_valid_i = 1'b1; bus.req1_we_i = 1'b0; bus.req1_addr_i = 32'h14;
    #1;
    chk("rd_ready1", {bus.req1_ready_o, bus.req0_ready_o}, 64'h2);
    tick();
    bus.req1_valid_i = 1'b0;
    chk("rd_arvalid", 32'(bus.cfg_arvalid_o), 32'd1);
    chk("rd_araddr",  bus.cfg_araddr_o, 64'h14);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rd_ar_hold", {bus.cfg_arvalid_o, bus.cfg_rready_o, bus.cfg_araddr_o}, 64'h2_0000_0014);
    end
    bus.cfg_arready_i = 1'b1;
    tick();
    bus.cfg_arready_i = 1'b0;
    chk("rd_ar_done", {bus.cfg_arvalid_o, bus.cfg_rready_o}, 64'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rd_r_wait", {bus.cfg_rready_o, bus.req1_done_o, bus.req0_done_o}, 64'h4);
    end
    bus.cfg_rvalid_i = 1'b1; bus.cfg_rdata_i = 32'hDEAD_BEEF; bus.cfg_rresp_i = 2'b10;
    tick();
    slave_idle();
    chk("rd_done1",  {bus.req1_done_o, bus.req0_done_o}, 64'h2);
    chk("rd_rdata1", bus.req1_rdata_o, 64'hDEAD_BEEF);
    chk("rd_resp1",  bus.req1_resp_o,  64'h2);
    chk("rd_req0_hold", {bus.req0_rdata_o, 30'd0, bus.req0_resp_o}, 64'h0);
    tick();
    chk("rd_done_pulse", {bus.req1_done_o, bus.cfg_rready_o}, 64'h0);

    // ---------------- contention: 4 commands each, alternating grants
    bus.req0_valid_i = 1'b1; bus.req0_we_i = 1'b1;
    bus.req0_addr_i  = 32'h20; bus.req0_wdata_i = 32'h5555_AAAA;
    bus.req1_valid_i = 1'b1; bus.req1_we_i = 1'b0; bus.req1_addr_i = 32'h24;
    bus.cfg_awready_i = 1'b1; bus.cfg_wready_i = 1'b1;
    bus.cfg_bvalid_i  = 1'b1; bus.cfg_bresp_i  = 2'b01;
    bus.cfg_arready_i = 1'b1; bus.cfg_rvalid_i = 1'b1;
    bus.cfg_rdata_i   = 32'h1234_5678; bus.cfg_rresp_i = 2'b00;
    #1;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (!(bus.req0_ready_o || bus.req1_ready_o) && n < 10) begin
        tick(); n++;
      end
      chk("cont_grant", {bus.req1_ready_o, bus.req0_ready_o}, (k % 2 == 1) ? 64'h2 : 64'h1);
      tick();
      if (k == 6) bus.req0_valid_i = 1'b0;
      if (k == 7) bus.req1_valid_i = 1'b0;
      n = 0;
      while (!(bus.req0_done_o || bus.req1_done_o) && n < 10) begin
        tick(); n++;
      end
      chk("cont_done", {bus.req1_done_o, bus.req0_done_o}, (k % 2 == 1) ? 64'h2 : 64'h1);
      if (k % 2 == 1)
        chk("cont_rd1", {bus.req1_rdata_o, 30'd0, bus.req1_resp_o}, {32'h1234_5678, 32'h0});
      else
        chk("cont_wr0", {bus.req0_rdata_o, 30'd0, bus.req0_resp_o}, 64'h1);
    end
    tick();
    chk("cont_end_idle", {bus.busy_o, bus.req0_ready_o, bus.req1_ready_o}, 64'h0);
    slave_idle();

    // ---------------- split write: W before AW
    bus.req0_valid_i = 1'b1; bus.req0_we_i = 1'b1;
    bus.req0_addr_i  = 32'h30; bus.req0_wdata_i = 32'h1111_2222;
    tick();
    bus.req0_valid_i = 1'b0;
    chk("sp1_start", {bus.cfg_awvalid_o, bus.cfg_wvalid_o}, 64'h3);
    bus.cfg_wready_i = 1'b1;
    tick();
    bus.cfg_wready_i = 1'b0;
    chk("sp1_w_first", {bus.cfg_awvalid_o, bus.cfg_wvalid_o, bus.cfg_bready_o}, 64'h4);
    tick();
    chk("sp1_aw_hold", {bus.cfg_awvalid_o, bus.cfg_wvalid_o, bus.cfg_bready_o, bus.cfg_awaddr_o}, 64'h4_0000_0030);
    bus.cfg_awready_i = 1'b1;
    tick();
    bus.cfg_awready_i = 1'b0;
    chk("sp1_aw_done", {bus.cfg_awvalid_o, bus.cfg_wvalid_o, bus.cfg_bready_o}, 64'h1);
    bus.cfg_bvalid_i = 1'b1; bus.cfg_bresp_i = 2'b10;
    tick();
    bus.cfg_bvalid_i = 1'b0;
    chk("sp1_done", {bus.req0_done_o, 30'd0, bus.req0_resp_o}, {32'h1, 32'h2});
    tick();
    chk("sp1_one_b", {bus.cfg_bready_o, bus.req0_done_o, bus.busy_o}, 64'h0);

    // ---------------- split write: AW before W
    bus.req1_valid_i = 1'b1; bus.req1_we_i = 1'b1;
    bus.req1_addr_i  = 32'h34; bus.req1_wdata_i = 32'h3333_4444;
    tick();
    bus.req1_valid_i = 1'b0;
    bus.cfg_awready_i = 1'b1;
    tick();
    bus.cfg_awready_i = 1'b0;
    chk("sp2_aw_first", {bus.cfg_awvalid_o, bus.cfg_wvalid_o, bus.cfg_bready_o}, 64'h2);
    tick();
    chk("sp2_w_hold", {bus.cfg_wvalid_o, bus.cfg_wdata_o}, 64'h1_3333_4444);
    bus.cfg_wready_i = 1'b1;
    tick();
    bus.cfg_wready_i = 1'b0;
    chk("sp2_w_done", {bus.cfg_awvalid_o, bus.cfg_wvalid_o, bus.cfg_bready_o}, 64'h1);
    bus.cfg_bvalid_i = 1'b1; bus.cfg_bresp_i = 2'b00;
    tick();
    bus.cfg_bvalid_i = 1'b0;
    chk("sp2_done", {bus.req1_done_o, bus.req0_done_o}, 64'h2);
    chk("sp2_wr_rdata_zero", {bus.req1_rdata_o, 30'd0, bus.req1_resp_o}, 64'h0);
    tick();
    chk("sp2_one_b", {bus.cfg_bready_o, bus.req1_done_o, bus.busy_o}, 64'h0);

    // ---------------- reset during RD_RESP
    bus.req0_valid_i = 1'b1; bus.req0_we_i = 1'b0; bus.req0_addr_i = 32'h40;
    bus.cfg_arready_i = 1'b1;
    tick();
    bus.req0_valid_i = 1'b0;
    tick();
    bus.cfg_arready_i = 1'b0;
    chk("mr_in_rresp", {bus.cfg_rready_o, bus.busy_o}, 64'h3);
    rst_i = 1'b0;
    #1;
    chk("mr_outputs", {bus.cfg_rready_o, bus.cfg_arvalid_o, bus.busy_o,
                       bus.req0_done_o, bus.req1_done_o}, 64'h0);
    chk("mr_addr", {bus.cfg_araddr_o, bus.cfg_awaddr_o}, 64'h0);
    chk("mr_rdata", {bus.req0_rdata_o, 30'd0, bus.req0_resp_o}, 64'h0);
    tick();
    chk("mr_no_done", {bus.req0_done_o, bus.req1_done_o}, 64'h0);
    rst_i = 1'b1;
    bus.req1_valid_i = 1'b1; bus.req1_we_i = 1'b0; bus.req1_addr_i = 32'h44;
    bus.cfg_arready_i = 1'b1; bus.cfg_rvalid_i = 1'b1;
    bus.cfg_rdata_i = 32'hCAFE_F00D; bus.cfg_rresp_i = 2'b00;
    #1;
    chk("mr_new_ready", {bus.req1_ready_o, bus.req0_done_o}, 64'h2);
    tick();
    bus.req1_valid_i = 1'b0;
    tick();
    tick();
    chk("mr_new_done", {bus.req1_done_o, bus.req1_rdata_o}, 64'h1_CAFE_F00D);
    chk("mr_req0_quiet", 32'(bus.req0_done_o), 32'd0);
    slave_idle();
    tick();
    chk("mr_final_idle", {bus.busy_o, bus.req1_done_o}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
